// File: rtl/signa_gen_pkg.sv
// Shared constants for the GPS L1 C/A signal generator: counter limits,
// PRN G2 tap table and the quarter-wave sine ROM with its lookup helper.
package signa_gen_pkg;

  localparam logic [9:0]  CHIP_LAST = 10'd1022;
  localparam logic [14:0] NAV_LAST  = 15'd20459;
  localparam logic [8:0]  ADDR_LAST = 9'd299;

  // G2 phase-select taps per PRN; entry 0 is selected for invalid PRNs, whose outputs are forced to 0
  localparam logic [3:0] G2_TAP_A [0:32] = '{
    4'd1,
    4'd2, 4'd3, 4'd4, 4'd5, 4'd1, 4'd2, 4'd1, 4'd2, 4'd3, 4'd2,
    4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd1, 4'd2, 4'd3, 4'd4,
    4'd5, 4'd6, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd1, 4'd2,
    4'd3, 4'd4
  };
  localparam logic [3:0] G2_TAP_B [0:32] = '{
    4'd1,
    4'd6, 4'd7, 4'd8, 4'd9, 4'd9, 4'd10, 4'd8, 4'd9, 4'd10, 4'd3,
    4'd4, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd4, 4'd5, 4'd6, 4'd7,
    4'd8, 4'd9, 4'd3, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd6, 4'd7,
    4'd8, 4'd9
  };

  // round(2047*sin(2*pi*k/256)), k = 0..63
  localparam logic [10:0] QROM [0:63] = '{
    11'd0,    11'd50,   11'd100,  11'd151,  11'd201,  11'd251,  11'd300,  11'd350,
    11'd399,  11'd449,  11'd497,  11'd546,  11'd594,  11'd642,  11'd690,  11'd737,
    11'd783,  11'd830,  11'd875,  11'd920,  11'd965,  11'd1009, 11'd1052, 11'd1095,
    11'd1137, 11'd1179, 11'd1219, 11'd1259, 11'd1299, 11'd1337, 11'd1375, 11'd1411,
    11'd1447, 11'd1483, 11'd1517, 11'd1550, 11'd1582, 11'd1614, 11'd1644, 11'd1674,
    11'd1702, 11'd1729, 11'd1756, 11'd1781, 11'd1805, 11'd1828, 11'd1850, 11'd1871,
    11'd1891, 11'd1910, 11'd1927, 11'd1944, 11'd1959, 11'd1973, 11'd1986, 11'd1997,
    11'd2008, 11'd2017, 11'd2025, 11'd2032, 11'd2037, 11'd2041, 11'd2045, 11'd2046
  };

  // Full-cycle sine from the quarter table; the 90/270 degree peaks are not
  // in the table and return the amplitude directly.
  function automatic logic [11:0] wave_lookup(input logic [7:0] p, input int amp);
    logic [5:0] idx;
    int         mag;
    idx = p[6] ? 6'(6'd0 - p[5:0]) : p[5:0];
    if (p[6] && (p[5:0] == 6'd0)) mag = amp;
    else                          mag = (int'(QROM[idx]) * amp + 1023) / 2047;
    return p[7] ? 12'(-mag) : 12'(mag);
  endfunction

endpackage

// File: rtl/signa_gen_ca_code_gen.sv
// C/A code generator: G1/G2 LFSRs with PRN phase-select taps and epoch reload.
module ca_code_gen
  import signa_gen_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  input  logic       strobe,
  input  logic       epoch,
  input  logic [5:0] sv_num,
  output logic       chip
);

  logic [10:1] g1;
  logic [10:1] g2;
  logic [5:0]  sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g1 <= '1;
      g2 <= '1;
    end else if (hold || (strobe && epoch)) begin
      g1 <= '1;
      g2 <= '1;
    end else if (strobe) begin
      g1 <= {g1[9:1], g1[3] ^ g1[10]};
      g2 <= {g2[9:1], g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10]};
    end
  end

  assign sel  = ((sv_num != 6'd0) && (sv_num <= 6'd32)) ? sv_num : 6'd0;
  assign chip = g1[10] ^ g2[G2_TAP_A[sel]] ^ g2[G2_TAP_B[sel]];

endmodule

// File: rtl/signa_gen.sv
// GPS L1 C/A baseband signal generator: carrier/code NCOs, nav data
// sequencing and BPSK-modulated I/Q sample output.
module signa_gen
  import signa_gen_pkg::*;
#(
  parameter int AMP = 2047
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send_en,
  input  logic [5:0]  sv_num,
  input  logic [61:0] fcarr_control,
  input  logic [61:0] fcode_control,
  input  logic [62:0] phase_init_carrier,
  input  logic [62:0] phase_init_code,
  input  logic [14:0] phase_init_navidata,
  input  logic [8:0]  address_init_navidata,
  input  logic [9:0]  code_cnt_init,
  input  logic [63:0] message1,
  input  logic [63:0] message2,
  input  logic [63:0] message3,
  input  logic [63:0] message4,
  input  logic [63:0] message5,
  input  logic        shut_time6s_sign,
  output logic [11:0] signal_sin,
  output logic [11:0] signal_cos,
  output logic [63:0] acc_sum_carrier,
  output logic [63:0] acc_sum_code,
  output logic [14:0] acc_sum_navidata,
  output logic [8:0]  address_navidata,
  output logic [9:0]  code_cnt,
  output logic        time6s_sign
);

  logic [63:0]  carr_sum;
  logic [63:0]  code_sum;
  logic         strobe;
  logic         code_wrap;
  logic         nav_wrap;
  logic         addr_wrap;
  logic         chip;
  logic         data_bit;
  logic         mod;
  logic         sv_valid;
  logic [319:0] msg_all;
  logic [8:0]   bit_idx;
  logic [11:0]  sin_val;
  logic [11:0]  cos_val;

  assign carr_sum  = {1'b0, acc_sum_carrier[62:0]} + {2'b00, fcarr_control};
  assign code_sum  = {1'b0, acc_sum_code[62:0]} + {2'b00, fcode_control};
  assign strobe    = acc_sum_code[63];
  // Out-of-range preloads are treated as already at the limit
  assign code_wrap = code_cnt >= CHIP_LAST;
  assign nav_wrap  = acc_sum_navidata >= NAV_LAST;
  assign addr_wrap = address_navidata >= ADDR_LAST;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_sum_carrier  <= '0;
      acc_sum_code     <= '0;
      acc_sum_navidata <= '0;
      address_navidata <= '0;
      code_cnt         <= '0;
    end else if (!send_en) begin
      acc_sum_carrier  <= {1'b0, phase_init_carrier};
      acc_sum_code     <= {1'b0, phase_init_code};
      acc_sum_navidata <= phase_init_navidata;
      address_navidata <= address_init_navidata;
      code_cnt         <= code_cnt_init;
    end else begin
      acc_sum_carrier <= carr_sum;
      acc_sum_code    <= code_sum;
      if (strobe) begin
        code_cnt         <= code_wrap ? 10'd0 : code_cnt + 10'd1;
        acc_sum_navidata <= nav_wrap ? 15'd0 : acc_sum_navidata + 15'd1;
        if (nav_wrap) address_navidata <= addr_wrap ? 9'd0 : address_navidata + 9'd1;
      end
    end
  end

  // Sticky 6 s subframe flag; a wrap in the same cycle as a clear keeps it set
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          time6s_sign <= 1'b0;
    else if (send_en && strobe && nav_wrap && addr_wrap) time6s_sign <= 1'b1;
    else if (shut_time6s_sign)                        time6s_sign <= 1'b0;
  end

  ca_code_gen u_ca_code_gen (
    .clk    (clk),
    .rst    (rst),
    .hold   (!send_en),
    .strobe (send_en && strobe),
    .epoch  (code_wrap),
    .sv_num (sv_num),
    .chip   (chip)
  );

  assign msg_all  = {message1, message2, message3, message4, message5};
  assign bit_idx  = 9'd319 - address_navidata;
  assign data_bit = msg_all[bit_idx];
  assign mod      = chip ^ data_bit;
  assign sv_valid = (sv_num != 6'd0) && (sv_num <= 6'd32);
  assign sin_val  = wave_lookup(acc_sum_carrier[62:55], AMP);
  assign cos_val  = wave_lookup(acc_sum_carrier[62:55] + 8'd64, AMP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      signal_sin <= '0;
      signal_cos <= '0;
    end else if (!send_en || !sv_valid) begin
      signal_sin <= '0;
      signal_cos <= '0;
    end else begin
      signal_sin <= mod ? 12'(-sin_val) : sin_val;
      signal_cos <= mod ? 12'(-cos_val) : cos_val;
    end
  end

endmodule

// File: tb/tb_signa_gen.sv
// Directed bench for signa_gen: vector table for the I/Q mapping plus
// hand-written sequences for counter wraps, PRN chips and NCO rates.
module tb_signa_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        send_en;
  logic [5:0]  sv_num;
  logic [61:0] fcarr_control, fcode_control;
  logic [62:0] phase_init_carrier, phase_init_code;
  logic [14:0] phase_init_navidata;
  logic [8:0]  address_init_navidata;
  logic [9:0]  code_cnt_init;
  logic [63:0] message1, message2, message3, message4, message5;
  logic        shut_time6s_sign;
  logic [11:0] signal_sin, signal_cos;
  logic [63:0] acc_sum_carrier, acc_sum_code;
  logic [14:0] acc_sum_navidata;
  logic [8:0]  address_navidata;
  logic [9:0]  code_cnt;
  logic        time6s_sign;

  int total = 0;
  int bad   = 0;

  signa_gen #(.AMP(2047)) dut (
    .clk(clk), .rst(rst), .send_en(send_en), .sv_num(sv_num),
    .fcarr_control(fcarr_control), .fcode_control(fcode_control),
    .phase_init_carrier(phase_init_carrier), .phase_init_code(phase_init_code),
    .phase_init_navidata(phase_init_navidata), .address_init_navidata(address_init_navidata),
    .code_cnt_init(code_cnt_init),
    .message1(message1), .message2(message2), .message3(message3),
    .message4(message4), .message5(message5),
    .shut_time6s_sign(shut_time6s_sign),
    .signal_sin(signal_sin), .signal_cos(signal_cos),
    .acc_sum_carrier(acc_sum_carrier), .acc_sum_code(acc_sum_code),
    .acc_sum_navidata(acc_sum_navidata), .address_navidata(address_navidata),
    .code_cnt(code_cnt), .time6s_sign(time6s_sign)
  );

  always #4 clk = ~clk;

  typedef struct {
    logic [7:0] idx;
    logic [5:0] sv;
    logic       dbit;
    int         exp_sin;
    int         exp_cos;
  } vec_t;

  vec_t vecs [11];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic defaults();
    send_en = 1'b0; sv_num = 6'd1;
    fcarr_control = '0; fcode_control = '0;
    phase_init_carrier = '0; phase_init_code = '0;
    phase_init_navidata = '0; address_init_navidata = '0; code_cnt_init = '0;
    message1 = '0; message2 = '0; message3 = '0; message4 = '0; message5 = '0;
    shut_time6s_sign = 1'b0;
  endtask

  // Arms exactly one code strobe: the code phase sits one LSB below the carry
  task automatic arm_one_strobe();
    send_en = 1'b0;
    phase_init_code = '1;
    fcode_control = 62'd1;
    tick(1);
    send_en = 1'b1;
  endtask

  initial begin
    logic [9:0] prn1_chips;
    int cs, cc, peak, v;
    prn1_chips = 10'b1100100000;

    vecs[0]  = '{8'd0,   6'd1,  1'b1, 0,     2047};
    vecs[1]  = '{8'd64,  6'd1,  1'b1, 2047,  0};
    vecs[2]  = '{8'd32,  6'd5,  1'b1, 1447,  1447};
    vecs[3]  = '{8'd128, 6'd32, 1'b1, 0,     -2047};
    vecs[4]  = '{8'd192, 6'd7,  1'b1, -2047, 0};
    vecs[5]  = '{8'd10,  6'd1,  1'b0, -497,  -1986};
    vecs[6]  = '{8'd200, 6'd2,  1'b1, -2008, 399};
    vecs[7]  = '{8'd100, 6'd9,  1'b0, -1299, 1582};
    vecs[8]  = '{8'd64,  6'd0,  1'b1, 0,     0};
    vecs[9]  = '{8'd64,  6'd33, 1'b0, 0,     0};
    vecs[10] = '{8'd32,  6'd20, 1'b0, -1447, -1447};

    // Reset with generation requested and non-zero preloads
    defaults();
    rst = 1'b1;
    send_en = 1'b1;
    code_cnt_init = 10'd77; phase_init_navidata = 15'd123; address_init_navidata = 9'd45;
    phase_init_carrier = 63'h1234_5678_9abc_def0; fcarr_control = 62'd1000; fcode_control = 62'd1000;
    tick(3);
    chk("rst_sin", signal_sin, 0);
    chk("rst_cos", signal_cos, 0);
    chk("rst_carr", acc_sum_carrier, 0);
    chk("rst_code", acc_sum_code, 0);
    chk("rst_nav", acc_sum_navidata, 0);
    chk("rst_addr", address_navidata, 0);
    chk("rst_cnt", code_cnt, 0);
    chk("rst_t6s", time6s_sign, 0);
    send_en = 1'b0;
    rst = 1'b0;
    tick(2);
    chk("hold_cnt", code_cnt, 77);
    chk("hold_nav", acc_sum_navidata, 123);
    chk("hold_addr", address_navidata, 45);
    chk("hold_carr", acc_sum_carrier, longint'({1'b0, 63'h1234_5678_9abc_def0}));
    chk("hold_sin", signal_sin, 0);

    // I/Q mapping: frozen NCOs, code at epoch (chip = 1 for every PRN)
    for (int k = 0; k < 11; k++) begin
      defaults();
      sv_num = vecs[k].sv;
      message1 = {vecs[k].dbit, 63'd0};
      phase_init_carrier = {vecs[k].idx, 55'd0};
      tick(1);
      send_en = 1'b1;
      tick(3);
      chk($sformatf("vec%0d_sin", k), longint'($signed(signal_sin)), vecs[k].exp_sin);
      chk($sformatf("vec%0d_cos", k), longint'($signed(signal_cos)), vecs[k].exp_cos);
    end

    // Nav word and address both at their last value: one strobe wraps both
    defaults();
    phase_init_navidata = 15'd20459; address_init_navidata = 9'd299; code_cnt_init = 10'd5;
    arm_one_strobe();
    tick(3);
    chk("wrap_nav", acc_sum_navidata, 0);
    chk("wrap_addr", address_navidata, 0);
    chk("wrap_cnt", code_cnt, 6);
    chk("wrap_t6s", time6s_sign, 1);
    tick(5);
    chk("t6s_sticky", time6s_sign, 1);
    #2 shut_time6s_sign = 1'b1;
    #20 shut_time6s_sign = 1'b0;
    tick(1);
    chk("t6s_clear", time6s_sign, 0);

    // Set and clear in the same cycle: set wins, the held clear acts next cycle
    defaults();
    phase_init_navidata = 15'd20459; address_init_navidata = 9'd299;
    shut_time6s_sign = 1'b1;
    arm_one_strobe();
    tick(2);
    chk("t6s_set_wins", time6s_sign, 1);
    tick(1);
    chk("t6s_clr_after", time6s_sign, 0);
    shut_time6s_sign = 1'b0;

    // Out-of-range preloads wrap at the first strobe
    defaults();
    code_cnt_init = 10'd1023; phase_init_navidata = 15'd20500; address_init_navidata = 9'd300;
    arm_one_strobe();
    tick(3);
    chk("oor_cnt", code_cnt, 0);
    chk("oor_nav", acc_sum_navidata, 0);
    chk("oor_addr", address_navidata, 0);

    // Data bit boundary: bit0 = 0, bit1 = 1, PRN1 chips 0 and 1 are both 1
    defaults();
    message1 = {2'b01, 62'd0};
    phase_init_carrier = {8'd64, 55'd0};
    phase_init_navidata = 15'd20459;
    arm_one_strobe();
    tick(1);
    chk("dbit_before", longint'($signed(signal_sin)), -2047);
    tick(2);
    chk("dbit_addr", address_navidata, 1);
    chk("dbit_after", longint'($signed(signal_sin)), 2047);

    // Real code rate from the last chip: epoch, then PRN1 first ten chips
    defaults();
    code_cnt_init = 10'd1022;
    fcode_control = 62'd75484076749619485;
    phase_init_carrier = {8'd64, 55'd0};
    tick(1);
    send_en = 1'b1;
    for (int c = 0; c < 300 && code_cnt == 10'd1022; c++) tick(1);
    chk("epoch_cnt", code_cnt, 0);
    for (int n = 0; n < 10; n++) begin
      for (int c = 0; c < 300 && code_cnt != 10'(n); c++) tick(1);
      chk($sformatf("chip%0d_cnt", n), code_cnt, n);
      tick(3);
      chk($sformatf("chip%0d_sin", n), longint'($signed(signal_sin)),
          prn1_chips[9-n] ? -2047 : 2047);
    end

    // Carrier and code NCO rates plus output peak over 1222 cycles
    send_en = 1'b0;
    fcarr_control = 62'd301936306998477940;
    phase_init_carrier = '0;
    tick(1);
    send_en = 1'b1;
    cs = 0; cc = 0; peak = 0;
    for (int c = 0; c < 1222; c++) begin
      tick(1);
      if (acc_sum_code[63]) cs++;
      if (acc_sum_carrier[63]) cc++;
      v = int'($signed(signal_sin));
      if (v < 0) v = -v;
      if (v > peak) peak = v;
    end
    chk_rng("code_rate", cs, 9, 11);
    chk_rng("carr_rate", cc, 39, 41);
    chk_rng("sin_peak", peak, 2046, 2047);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
